mem_stage_hs: RTL

- Parametrised successor MEM pipeline stage. Sits between EX and WB; replaces the zero-latency data-memory hookup with a request/response handshake to an external variable-latency data memory.
- Generates byte enables and aligned store data, and extracts plus sign/zero-extends load data.
- Flags misaligned accesses and bus timeouts.
- Exerts back-pressure upstream via in_ready, and holds its registered result until WB accepts it.

---
 rtl/mem_stage_pkg.sv | 58 +++++
 rtl/mem_stage_hs_align.sv | 72 +++++++
 rtl/mem_stage_hs.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the handshaked MEM stage.
// Helpers work on a 64-bit view; callers truncate to their own data width.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_B = 2'b00,
        ST_H = 2'b01,
        ST_W = 2'b10,
        ST_D = 2'b11
    } store_type_e;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_D  = 3'b011,
        LD_BU = 3'b100,
        LD_HU = 3'b101,
        LD_WU = 3'b110
    } load_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Byte-enable mask of 2**size_l2 bytes placed at the given lane.
    function automatic logic [7:0] lane_be(input logic [1:0] size_l2, input logic [2:0] lane);
        logic [7:0] mask;
        case (size_l2)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            2'd3:    mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask << lane;
    endfunction

    // Sign- or zero-extends the low bytes of an already lane-shifted word.
    function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [2:0] ltype);
        logic [63:0] ext;
        case (ltype)
            LD_B:    ext = {{56{raw[7]}}, raw[7:0]};
            LD_H:    ext = {{48{raw[15]}}, raw[15:0]};
            LD_W:    ext = {{32{raw[31]}}, raw[31:0]};
            LD_D:    ext = raw;
            LD_BU:   ext = {56'h0, raw[7:0]};
            LD_HU:   ext = {48'h0, raw[15:0]};
            LD_WU:   ext = {32'h0, raw[31:0]};
            default: ext = 64'h0;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mem_stage_hs_align.sv
// Combinational lane logic: byte enables, store replication, alignment/legality
// check on the request side, and load extraction on the response side.
module mem_align_unit #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          addr_lo_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic                is_store_i,
    input  logic                is_load_i,
    input  logic [1:0]          store_type_i,
    input  logic [2:0]          load_type_i,
    output logic [DATA_W/8-1:0] be_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                misaligned_o,
    input  logic [2:0]          rsp_lane_i,
    input  logic [2:0]          rsp_load_type_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W-1:0]   load_data_o
);
    import mem_stage_pkg::*;

    localparam int         BYTES     = DATA_W / 8;
    localparam logic [2:0] LANE_MASK = 3'(BYTES - 1);

    logic [1:0]        size_s;
    logic              illegal_s;
    logic [2:0]        align_mask_s;
    logic [DATA_W-1:0] shifted_s;

    // Access size, legality for this data width, and required alignment mask.
    always_comb begin
        size_s       = 2'b00;
        illegal_s    = 1'b0;
        align_mask_s = 3'b000;
        if (is_store_i) begin
            size_s    = store_type_i;
            illegal_s = (DATA_W == 32) && (store_type_i == ST_D);
        end else begin
            size_s    = load_type_i[1:0];
            illegal_s = (load_type_i == 3'b111) ||
                        ((DATA_W == 32) && ((load_type_i == LD_D) || (load_type_i == LD_WU)));
        end
        case (size_s)
            2'd0:    align_mask_s = 3'b000;
            2'd1:    align_mask_s = 3'b001;
            2'd2:    align_mask_s = 3'b011;
            2'd3:    align_mask_s = 3'b111;
            default: align_mask_s = 3'b000;
        endcase
    end

    assign misaligned_o = (is_store_i || is_load_i) &&
                          (illegal_s || (|(addr_lo_i & align_mask_s)));

    // Byte enables at the addressed lane and store data copied into every lane.
    always_comb begin
        be_o = BYTES'(lane_be(size_s, addr_lo_i & LANE_MASK));
        case (size_s)
            2'd0:    wdata_o = {BYTES{st_data_i[7:0]}};
            2'd1:    wdata_o = {(BYTES/2){st_data_i[15:0]}};
            2'd2:    wdata_o = {(BYTES/4){st_data_i[31:0]}};
            default: wdata_o = st_data_i;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend per load type.
    always_comb begin
        shifted_s   = rdata_i >> {rsp_lane_i, 3'b000};
        load_data_o = DATA_W'(load_extend(64'(shifted_s), rsp_load_type_i));
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage talking to a variable-latency data memory over a
// request/response handshake, with timeout and WB back-pressure.
module mem_stage_hs #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   result_alu,
    input  logic [DATA_W-1:0]   op2_data,
    input  logic                mem_write,
    input  logic                mem_read,
    input  logic [1:0]          store_type,
    input  logic [2:0]          load_type,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   read_data,
    output logic [DATA_W-1:0]   calculated_result,
    output logic                misaligned,
    output logic                bus_err,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic                dmem_we,
    output logic [DATA_W/8-1:0] dmem_be,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_rsp_valid,
    input  logic [DATA_W-1:0]   dmem_rdata
);
    import mem_stage_pkg::*;

    localparam int                BYTES     = DATA_W / 8;
    localparam logic [2:0]        LANE_MASK = 3'(BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BYTES - 1);
    localparam int                CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit                TO_EN     = (TIMEOUT != 0);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic              req_valid_q;
    logic              misal_q;
    logic              bus_err_q;
    logic              we_q;
    logic [DATA_W-1:0] calc_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTES-1:0]  be_q;
    logic [2:0]        lane_q;
    logic [2:0]        ltype_q;

    logic              accept_s;
    logic              is_load_s;
    logic              is_mem_s;
    logic              timeout_s;
    logic              misal_s;
    logic [BYTES-1:0]  be_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] load_data_s;

    // A simultaneous read+write is handled as a store.
    assign is_load_s = mem_read && !mem_write;
    assign is_mem_s  = mem_read || mem_write;
    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign timeout_s = TO_EN && (cnt_q == CNT_LAST);

    mem_align_unit #(
        .DATA_W(DATA_W)
    ) u_align (
        .addr_lo_i       (result_alu[2:0]),
        .st_data_i       (op2_data),
        .is_store_i      (mem_write),
        .is_load_i       (is_load_s),
        .store_type_i    (store_type),
        .load_type_i     (load_type),
        .be_o            (be_s),
        .wdata_o         (wdata_s),
        .misaligned_o    (misal_s),
        .rsp_lane_i      (lane_q),
        .rsp_load_type_i (ltype_q),
        .rdata_i         (dmem_rdata),
        .load_data_o     (load_data_s)
    );

    // Handshake FSM; every externally visible value is held in a register here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            misal_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            we_q        <= 1'b0;
            calc_q      <= {DATA_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            be_q        <= {BYTES{1'b0}};
            lane_q      <= 3'b000;
            ltype_q     <= 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        calc_q    <= result_alu;
                        rdata_q   <= {DATA_W{1'b0}};
                        misal_q   <= misal_s;
                        bus_err_q <= 1'b0;
                        if (is_mem_s && !misal_s) begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                            out_valid_q <= 1'b0;
                            cnt_q       <= {CNT_W{1'b0}};
                            addr_q      <= ADDR_W'(result_alu) & ADDR_MASK;
                            we_q        <= mem_write;
                            be_q        <= be_s;
                            wdata_q     <= wdata_s;
                            lane_q      <= result_alu[2:0] & LANE_MASK;
                            ltype_q     <= load_type;
                        end else begin
                            out_valid_q <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    // A grant in the last allowed cycle wins over the timeout.
                    if (dmem_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= {CNT_W{1'b0}};
                        if (we_q) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (timeout_s) begin
                        req_valid_q <= 1'b0;
                        bus_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (TO_EN) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dmem_rsp_valid) begin
                        rdata_q     <= load_data_s;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (timeout_s) begin
                        bus_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (TO_EN) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_valid_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid         = out_valid_q;
    assign read_data         = rdata_q;
    assign calculated_result = calc_q;
    assign misaligned        = misal_q;
    assign bus_err           = bus_err_q;
    assign dmem_req_valid    = req_valid_q;
    assign dmem_addr         = addr_q;
    assign dmem_we           = we_q;
    assign dmem_be           = be_q;
    assign dmem_wdata        = wdata_q;

endmodule
